apb_requester_q: RTL

Parametrised APB4 requester with a buffered command queue. Sits between the master/testbench and the APB completers, replacing per-request completer selection with address decoding. Accepts requests through a valid/ready port into a DEPTH-entry FIFO and drives one APB transfer at a time. Supports PSTRB, PSLVERR, decode errors and a wait-state timeout, and returns one response per request on a valid/ready port.

---
 rtl/apb_requester_q.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/apb_requester_q.sv
`timescale 1ns/1ps
// APB4 requester: buffers requests in a DEPTH-entry FIFO, decodes the completer from the
// address, runs one APB transfer at a time and returns one in-order response per request.
module apb_requester_q #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NCOMP      = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SEL_LSB    = 12,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [NCOMP-1:0]        PSELx,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic [DATA_WIDTH-1:0]   PRDATA
);
    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned IW = $clog2(NCOMP);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                state_q, state_d;
    logic                  fifo_write_q [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata_q [DEPTH];
    logic [SW-1:0]         fifo_strb_q  [DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [SW-1:0]         pstrb_q;
    logic [IW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [TW-1:0]         wait_q;

    logic                  push, pop, empty, head_err, timeout_hit;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic [SW-1:0]         head_strb;

    assign empty      = (count_q == '0);
    assign req_ready  = (count_q != CW'(DEPTH));
    assign push       = req_valid && req_ready;
    assign pop        = !empty && ((state_q == StIdle) || (state_q == StResp && rsp_ready));
    assign head_write = fifo_write_q[rptr_q];
    assign head_addr  = fifo_addr_q[rptr_q];
    assign head_wdata = fifo_wdata_q[rptr_q];
    assign head_strb  = fifo_strb_q[rptr_q];
    // Any address bit above the completer-index field means no completer owns it.
    assign head_err   = |(head_addr >> (SEL_LSB + IW));
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_write_q[wptr_q] <= req_write;
            fifo_addr_q[wptr_q]  <= req_addr;
            fifo_wdata_q[wptr_q] <= req_wdata;
            fifo_strb_q[wptr_q]  <= req_strb;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!empty) state_d = head_err ? StResp : StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (PREADY || timeout_hit) state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    if (!empty) state_d = head_err ? StResp : StSetup;
                    else        state_d = StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            idx_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wait_q   <= '0;
        end else if (pop) begin
            if (head_err) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else begin
                paddr_q  <= head_addr;
                pwrite_q <= head_write;
                pwdata_q <= head_write ? head_wdata : '0;
                pstrb_q  <= head_write ? head_strb : '0;
                idx_q    <= head_addr[SEL_LSB +: IW];
                wait_q   <= '0;
            end
        end else if (state_q == StAccess) begin
            // PREADY on the timeout edge takes priority: the transfer completes normally.
            if (PREADY) begin
                rdata_q <= pwrite_q ? '0 : PRDATA;
                err_q   <= PSLVERR;
            end else if (timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else begin
                wait_q <= wait_q + TW'(1);
            end
        end
    end

    always_comb begin
        PSELx     = '0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StSetup:  PSELx[idx_q] = 1'b1;
            StAccess: begin
                PSELx[idx_q] = 1'b1;
                PENABLE      = 1'b1;
            end
            StResp:   rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = !empty || (state_q != StIdle);

endmodule
